// File: rtl/tl45_scoreboard.sv
// rtl/tl45_scoreboard.sv - register-hazard scheduler with per-register pending-write counters
module tl45_scoreboard #(
   parameter int NREGS = 16,
   parameter int CNT_W = 2,
   parameter int INF_W = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_issue_valid,
   input  logic             i_issue_wr,
   input  logic [3:0]       i_issue_dr,
   input  logic [3:0]       i_issue_sr1,
   input  logic [3:0]       i_issue_sr2,
   output logic             o_issue_stall,
   input  logic             i_wb_valid,
   input  logic [3:0]       i_wb_dr,
   input  logic             i_flush,
   output logic [NREGS-1:0] o_busy_mask,
   output logic [INF_W-1:0] o_inflight,
   output logic             o_idle,
   output logic             o_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [INF_W-1:0] inflight_q, inflight_d;
   logic             idle_q, idle_d;
   logic             err_q, err_d;

   logic haz1, haz2, hazw, accept, inc, dec, same_reg;

   // Hazard detection from registered counts only; flush always blocks issue
   always_comb begin
      haz1          = (i_issue_sr1 != 4'd0) && (cnt_q[i_issue_sr1] != '0);
      haz2          = (i_issue_sr2 != 4'd0) && (cnt_q[i_issue_sr2] != '0);
      hazw          = i_issue_wr && (i_issue_dr != 4'd0) && (cnt_q[i_issue_dr] == CNT_MAX);
      o_issue_stall = i_flush || (i_issue_valid && (haz1 || haz2 || hazw));
      accept        = i_issue_valid && !o_issue_stall;
      inc           = accept && i_issue_wr && (i_issue_dr != 4'd0);
      dec           = i_wb_valid && (i_wb_dr != 4'd0) && !i_flush;
      same_reg      = (i_issue_dr == i_wb_dr);
   end

   // Next-state for counters, totals and the sticky underflow flag
   always_comb begin
      cnt_d      = cnt_q;
      inflight_d = inflight_q;
      err_d      = err_q;
      busy_d     = '0;
      if (i_flush) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = '0;
         end
         inflight_d = '0;
      end else if (!(inc && dec && same_reg)) begin
         if (inc) begin
            cnt_d[i_issue_dr] = cnt_q[i_issue_dr] + CNT_ONE;
            inflight_d        = inflight_d + INF_ONE;
         end
         if (dec) begin
            if (cnt_q[i_wb_dr] != '0) begin
               cnt_d[i_wb_dr] = cnt_q[i_wb_dr] - CNT_ONE;
               inflight_d     = inflight_d - INF_ONE;
            end else begin
               err_d = 1'b1;
            end
         end
      end
      // Register 0 is never tracked, so its busy bit stays clear
      for (int r = 1; r < NREGS; r++) begin
         busy_d[r] = (cnt_d[r] != '0);
      end
      idle_d = (inflight_d == '0);
   end

   // State registers with asynchronous reset
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q     <= '0;
         inflight_q <= '0;
         idle_q     <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
         idle_q     <= idle_d;
         err_q      <= err_d;
      end
   end

   assign o_busy_mask = busy_q;
   assign o_inflight  = inflight_q;
   assign o_idle      = idle_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_tl45_scoreboard.sv
// tb/tb_tl45_scoreboard.sv - self-checking bench for tl45_scoreboard
module tb_tl45_scoreboard;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_issue_valid, i_issue_wr;
   logic [3:0]  i_issue_dr, i_issue_sr1, i_issue_sr2;
   logic        o_issue_stall;
   logic        i_wb_valid;
   logic [3:0]  i_wb_dr;
   logic        i_flush;
   logic [15:0] o_busy_mask;
   logic [4:0]  o_inflight;
   logic        o_idle;
   logic        o_err;

   int checks   = 0;
   int failures = 0;

   tl45_scoreboard dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_issue_valid (i_issue_valid),
      .i_issue_wr    (i_issue_wr),
      .i_issue_dr    (i_issue_dr),
      .i_issue_sr1   (i_issue_sr1),
      .i_issue_sr2   (i_issue_sr2),
      .o_issue_stall (o_issue_stall),
      .i_wb_valid    (i_wb_valid),
      .i_wb_dr       (i_wb_dr),
      .i_flush       (i_flush),
      .o_busy_mask   (o_busy_mask),
      .o_inflight    (o_inflight),
      .o_idle        (o_idle),
      .o_err         (o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        v;
      logic        wr;
      logic [3:0]  dr;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        wbv;
      logic [3:0]  wbd;
      logic        fl;
      logic        e_stall;
      logic [15:0] e_busy;
      logic [4:0]  e_infl;
      logic        e_err;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] busy;
      logic [4:0]  infl;
      logic        err;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   function automatic vec_t mk(input logic v, input logic wr, input logic [3:0] dr,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic wbv, input logic [3:0] wbd, input logic fl,
                               input logic e_stall, input logic [15:0] e_busy,
                               input logic [4:0] e_infl, input logic e_err);
      vec_t t;
      t.v = v; t.wr = wr; t.dr = dr; t.s1 = s1; t.s2 = s2;
      t.wbv = wbv; t.wbd = wbd; t.fl = fl;
      t.e_stall = e_stall; t.e_busy = e_busy; t.e_infl = e_infl; t.e_err = e_err;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      i_issue_valid = 1'b0; i_issue_wr = 1'b0; i_issue_dr = 4'd0;
      i_issue_sr1 = 4'd0; i_issue_sr2 = 4'd0;
      i_wb_valid = 1'b0; i_wb_dr = 4'd0; i_flush = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic [15:0] busy,
                             input logic [4:0] infl, input logic err);
      chk({tag, "_busy"}, 32'(o_busy_mask), 32'(busy));
      chk({tag, "_inflight"}, 32'(o_inflight), 32'(infl));
      chk({tag, "_idle"}, 32'(o_idle), 32'(infl == 5'd0));
      chk({tag, "_err"}, 32'(o_err), 32'(err));
   endtask

   // Called at a negedge: drive, check stall, push expectation, clock, pop and compare
   task automatic apply(input int idx, input vec_t t);
      exp_t e, got;
      i_issue_valid = t.v; i_issue_wr = t.wr; i_issue_dr = t.dr;
      i_issue_sr1 = t.s1; i_issue_sr2 = t.s2;
      i_wb_valid = t.wbv; i_wb_dr = t.wbd; i_flush = t.fl;
      #1;
      chk($sformatf("v%0d_stall", idx), 32'(o_issue_stall), 32'(t.e_stall));
      e.idx = idx; e.busy = t.e_busy; e.infl = t.e_infl; e.err = t.e_err;
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      if (exp_q.size() == 0) begin
         chk($sformatf("v%0d_queue_empty", idx), 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         check_regs($sformatf("v%0d", got.idx), got.busy, got.infl, got.err);
      end
      @(negedge i_clk);
   endtask

   initial begin
      //                 v   wr  dr     s1     s2     wbv wbd    fl  stall busy      infl  err
      vecs.push_back(mk(1, 0, 4'd0,  4'd3,  4'd0,  0, 4'd0,  0,  0, 16'h0000, 5'd0, 0));
      // RAW on r5
      vecs.push_back(mk(1, 1, 4'd5,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0020, 5'd1, 0));
      vecs.push_back(mk(1, 0, 4'd0,  4'd5,  4'd0,  0, 4'd0,  0,  1, 16'h0020, 5'd1, 0));
      vecs.push_back(mk(1, 0, 4'd0,  4'd5,  4'd0,  1, 4'd5,  0,  1, 16'h0000, 5'd0, 0));
      vecs.push_back(mk(1, 0, 4'd0,  4'd5,  4'd0,  0, 4'd0,  0,  0, 16'h0000, 5'd0, 0));
      // saturation on r7, then r8 still accepted
      vecs.push_back(mk(1, 1, 4'd7,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0080, 5'd1, 0));
      vecs.push_back(mk(1, 1, 4'd7,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0080, 5'd2, 0));
      vecs.push_back(mk(1, 1, 4'd7,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0080, 5'd3, 0));
      vecs.push_back(mk(1, 1, 4'd7,  4'd0,  4'd0,  0, 4'd0,  0,  1, 16'h0080, 5'd3, 0));
      vecs.push_back(mk(1, 1, 4'd8,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0180, 5'd4, 0));
      vecs.push_back(mk(1, 0, 4'd0,  4'd0,  4'd8,  0, 4'd0,  0,  1, 16'h0180, 5'd4, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd7,  0,  0, 16'h0180, 5'd3, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd7,  0,  0, 16'h0180, 5'd2, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd7,  0,  0, 16'h0100, 5'd1, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd8,  0,  0, 16'h0000, 5'd0, 0));
      // simultaneous inc/dec
      vecs.push_back(mk(1, 1, 4'd4,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0010, 5'd1, 0));
      vecs.push_back(mk(1, 1, 4'd4,  4'd0,  4'd0,  1, 4'd4,  0,  0, 16'h0010, 5'd1, 0));
      vecs.push_back(mk(1, 1, 4'd11, 4'd0,  4'd0,  1, 4'd4,  0,  0, 16'h0800, 5'd1, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd11, 0,  0, 16'h0000, 5'd0, 0));
      vecs.push_back(mk(1, 1, 4'd12, 4'd0,  4'd0,  1, 4'd12, 0,  0, 16'h0000, 5'd0, 0));
      // flush with r2, r3, r9 pending
      vecs.push_back(mk(1, 1, 4'd2,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0004, 5'd1, 0));
      vecs.push_back(mk(1, 1, 4'd3,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h000C, 5'd2, 0));
      vecs.push_back(mk(1, 1, 4'd9,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h020C, 5'd3, 0));
      vecs.push_back(mk(1, 1, 4'd6,  4'd0,  4'd0,  1, 4'd2,  1,  1, 16'h0000, 5'd0, 0));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  0, 4'd0,  1,  1, 16'h0000, 5'd0, 0));
      // underflow, then R0 traffic, then sticky err through flush
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  1, 4'd10, 0,  0, 16'h0000, 5'd0, 1));
      vecs.push_back(mk(1, 1, 4'd0,  4'd0,  4'd0,  1, 4'd0,  0,  0, 16'h0000, 5'd0, 1));
      vecs.push_back(mk(1, 1, 4'd1,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0002, 5'd1, 1));
      vecs.push_back(mk(1, 0, 4'd0,  4'd0,  4'd1,  0, 4'd0,  0,  1, 16'h0002, 5'd1, 1));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  0, 4'd0,  1,  1, 16'h0000, 5'd0, 1));
      vecs.push_back(mk(0, 0, 4'd0,  4'd0,  4'd0,  0, 4'd0,  0,  0, 16'h0000, 5'd0, 1));

      // Reset held for a cycle while decode presents a read of r3
      drive_idle();
      i_reset = 1'b1;
      i_issue_valid = 1'b1; i_issue_sr1 = 4'd3;
      #1;
      chk("reset_stall", 32'(o_issue_stall), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      check_regs("reset", 16'h0000, 5'd0, 1'b0);
      chk("reset_release_stall", 32'(o_issue_stall), 32'd0);
      @(negedge i_clk);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(i, vecs[i]);
      end

      // Asynchronous reset mid-operation clears counts and the sticky error at once
      drive_idle();
      i_issue_valid = 1'b1; i_issue_wr = 1'b1; i_issue_dr = 4'd13;
      @(posedge i_clk);
      #1;
      drive_idle();
      check_regs("pre_async", 16'h2000, 5'd1, 1'b1);
      #2;
      i_reset = 1'b1;
      #1;
      check_regs("async_reset", 16'h0000, 5'd0, 1'b0);
      i_issue_valid = 1'b1; i_issue_sr1 = 4'd13;
      #1;
      chk("async_reset_stall", 32'(o_issue_stall), 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;
      drive_idle();
      @(posedge i_clk);
      #1;
      check_regs("post_async", 16'h0000, 5'd0, 1'b0);

      if (exp_q.size() != 0) begin
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tl45_scoreboard.md
Name: tl45_scoreboard

Overview:
- Register-hazard scheduler for the tl45 pipeline; sits beside the decode stage.
- Keeps a pending-write counter per architectural register and stalls issue of any instruction that reads a register with an outstanding write.
- Also stalls when the destination's counter is saturated.
- Writeback releases counters; a pipeline flush clears all of them.
- Register 0 is hardwired zero and is never tracked.

Parameters:
- NREGS, 16, number of architectural registers (index width fixed at 4 bits).
- CNT_W, 2, width of each pending counter; maximum in-flight writes per register is 2^CNT_W-1.
- INF_W, 5, width of the total in-flight counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  reset; asynchronous, active-high.
- i_issue_valid  input  1  decode presents an instruction for issue.
- i_issue_wr  input  1  the presented instruction writes i_issue_dr.
- i_issue_dr  input  4  destination register.
- i_issue_sr1  input  4  source register 1.
- i_issue_sr2  input  4  source register 2.
- o_issue_stall  output  1  combinational; instruction must not issue this cycle.
- i_wb_valid  input  1  writeback stage retires a register write.
- i_wb_dr  input  4  register being written back.
- i_flush  input  1  kill all in-flight instructions (branch/exception).
- o_busy_mask  output  NREGS  registered; bit r = (cnt[r] != 0); bit 0 is always 0.
- o_inflight  output  INF_W  registered; sum of all pending counters.
- o_idle  output  1  registered; o_inflight == 0.
- o_err  output  1  registered, sticky; writeback underflow detected.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all cnt[r]=0, o_busy_mask=0, o_inflight=0, o_idle=1, o_err=0.
  - o_issue_stall follows its combinational equation with all counts zero.
- Hazard terms, taken from registered counts only (no same-cycle writeback bypass):
  - haz1 = sr1!=0 && cnt[sr1]!=0.
  - haz2 = sr2!=0 && cnt[sr2]!=0.
  - hazw = i_issue_wr && dr!=0 && cnt[dr]==2^CNT_W-1.
- o_issue_stall = i_flush || (i_issue_valid && (haz1 || haz2 || hazw)).
  - With i_issue_valid=0, o_issue_stall = i_flush.
- Accept = i_issue_valid && !o_issue_stall.
- inc = accept && i_issue_wr && i_issue_dr!=0.
- dec = i_wb_valid && i_wb_dr!=0 && !i_flush.
- Per-cycle update when i_flush=0:
  - inc only: cnt[dr]+1.
  - dec only: if cnt[wb_dr]!=0 then cnt[wb_dr]-1; else count stays 0 and o_err<=1.
  - inc and dec on the same register: count unchanged, no error even if the count is 0.
  - inc and dec on different registers: both applied.
  - o_inflight tracks the net change (+1, -1, 0).
  - Counters never wrap, guaranteed by hazw.
- i_flush=1:
  - next cycle all cnt=0, o_inflight=0, o_idle=1.
  - issue and writeback in that cycle are ignored.
  - o_err is unchanged.
- Writes to register 0, and reads of register 0, have no effect and never cause a stall.
- Latency:
  - Issue is visible in o_busy_mask/o_inflight one cycle after the accepting edge.
  - A dependent instruction stalls from the cycle after the producer issues.
  - It may issue in the cycle after the writeback edge, i.e. at least one stall cycle beyond writeback.
- o_err clears only on reset.
- o_idle and o_busy_mask are registered copies, consistent with the counts on every cycle.

Test Plan:
- Reset then idle: hold i_reset 1 cycle with issue_valid=1, sr1=3 → after release o_busy_mask=0x0000, o_inflight=0, o_idle=1, o_issue_stall=0.
- RAW stall:
  - issue wr dr=5; next cycle issue sr1=5 → o_issue_stall=1, o_busy_mask=0x0020.
  - assert wb dr=5 for 1 cycle → stall still 1 during that cycle, 0 the cycle after; o_inflight returns 0.
- Saturation:
  - three accepted writes to dr=7 (no wb) → cnt[7]=3, o_inflight=3.
  - fourth write to dr=7 → o_issue_stall=1.
  - write to dr=8 → accepted, o_inflight=4.
- Simultaneous inc/dec: cnt[4]=1; in one cycle accept issue wr dr=4 and wb dr=4 → cnt[4] stays 1, o_inflight stays 1, o_err=0.
- Flush:
  - with dr 2,3,9 pending, assert i_flush together with issue wr dr=6 and wb dr=2 → o_issue_stall=1 that cycle.
  - next cycle o_busy_mask=0, o_inflight=0, o_idle=1.
- Underflow and R0:
  - wb dr=10 with cnt[10]=0 → o_err=1 next cycle, stays set until reset.
  - issue wr dr=0 and wb dr=0 → no count change, no stall, no error.
